cve2_fp_wb_arbiter: RTL and testbench

//  Write-side front end for the FP register file. Merges FP writebacks from the FPU (buffered) and the LSU (FLW load data, never stalled)

---
 rtl/cve2_fp_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_cve2_fp_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_fp_wb_arbiter.sv
// FP register-file write-port arbiter: LSU load data has priority over buffered FPU results,
// with a per-register pending scoreboard feeding the issue-stage RAW/WAW stall signals.
module cve2_fp_wb_arbiter #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 issue_valid_i,
    input  logic [4:0]           issue_rd_i,
    output logic                 issue_ready_o,
    input  logic [4:0]           rs_a_i,
    input  logic [4:0]           rs_b_i,
    input  logic [4:0]           rs_c_i,
    input  logic [2:0]           rs_use_i,
    output logic                 raw_stall_o,
    input  logic                 fpu_valid_i,
    output logic                 fpu_ready_o,
    input  logic [4:0]           fpu_rd_i,
    input  logic [DataWidth-1:0] fpu_wdata_i,
    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_rd_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic [4:0]           waddr_a_o,
    output logic [DataWidth-1:0] wdata_a_o,
    output logic                 we_a_o
);

    localparam int unsigned PtrW      = $clog2(FifoDepth);
    localparam logic [31:0] ValidMask = RV32E ? 32'h0000_FFFF : 32'hFFFF_FFFF;

    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [PtrW:0]        count;
    logic [4:0]           fifo_rd   [FifoDepth];
    logic [DataWidth-1:0] fifo_data [FifoDepth];

    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 sel_valid;
    logic [4:0]           sel_rd;
    logic [DataWidth-1:0] sel_data;
    logic                 issue_set;
    logic [31:0]          pending;
    logic [31:0]          pending_next;

    function automatic logic in_range(input logic [4:0] idx);
        return RV32E ? ~idx[4] : 1'b1;
    endfunction

    assign fifo_empty  = (count == '0);
    assign fpu_ready_o = (count != (PtrW+1)'(FifoDepth));
    // Flush discards the buffer, so neither a push nor a head pop may take effect alongside it.
    assign push        = fpu_valid_i & fpu_ready_o & ~flush_i;
    assign pop         = ~lsu_valid_i & ~fifo_empty & ~flush_i;

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (lsu_valid_i) begin
            sel_valid = 1'b1;
            sel_rd    = lsu_rd_i;
            sel_data  = lsu_wdata_i;
        end else if (pop) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_rd[rd_ptr];
            sel_data  = fifo_data[rd_ptr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= fpu_rd_i;
            fifo_data[wr_ptr] <= fpu_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            we_a_o    <= 1'b0;
            waddr_a_o <= '0;
            wdata_a_o <= '0;
        end else begin
            we_a_o <= sel_valid;
            if (sel_valid) begin
                waddr_a_o <= sel_rd;
                wdata_a_o <= sel_data;
            end
        end
    end

    assign issue_ready_o = ~(pending[issue_rd_i] & in_range(issue_rd_i));
    assign issue_set     = issue_valid_i & issue_ready_o;

    assign raw_stall_o = (rs_use_i[0] & pending[rs_a_i] & in_range(rs_a_i)) |
                         (rs_use_i[1] & pending[rs_b_i] & in_range(rs_b_i)) |
                         (rs_use_i[2] & pending[rs_c_i] & in_range(rs_c_i));

    // Set is applied after clear so a same-edge collision leaves the register pending.
    always_comb begin
        pending_next = pending;
        if (sel_valid && in_range(sel_rd))       pending_next[sel_rd]     = 1'b0;
        if (issue_set && in_range(issue_rd_i))   pending_next[issue_rd_i] = 1'b1;
        if (flush_i)                             pending_next             = '0;
        pending_next = pending_next & ValidMask;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) pending <= '0;
        else         pending <= pending_next;
    end

endmodule

// File: tb/tb_cve2_fp_wb_arbiter.sv
// Directed bench for cve2_fp_wb_arbiter: queue/bit-array reference model checked every cycle,
// plus literal expectations for latency, write order, scoreboard and flush scenarios.
module tb_cve2_fp_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs_a, rs_b, rs_c;
    logic [2:0]  rs_use;
    logic        raw_stall;
    logic        fpu_valid;
    logic        fpu_ready;
    logic [4:0]  fpu_rd;
    logic [31:0] fpu_wdata;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_wdata;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;

    cve2_fp_wb_arbiter #(.RV32E(1'b0), .DataWidth(32), .FifoDepth(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(issue_ready),
        .rs_a_i(rs_a), .rs_b_i(rs_b), .rs_c_i(rs_c), .rs_use_i(rs_use), .raw_stall_o(raw_stall),
        .fpu_valid_i(fpu_valid), .fpu_ready_o(fpu_ready), .fpu_rd_i(fpu_rd), .fpu_wdata_i(fpu_wdata),
        .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_wdata_i(lsu_wdata),
        .waddr_a_o(waddr), .wdata_a_o(wdata), .we_a_o(we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: FIFO as a queue, scoreboard as a bit array, registered write port.
    logic [36:0] mq[$];
    logic [31:0] mp;
    bit          model_ok = 0;
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    bit          m_sv, m_fr, m_ir;
    logic [4:0]  m_sr;
    logic [31:0] m_sd;
    logic [4:0]  wlog[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            mp = '0; ew = 1'b0; ea = '0; ed = '0;
            model_ok = 1;
        end else begin
            m_fr = (mq.size() < DEPTH);
            m_ir = !mp[issue_rd];
            m_sv = 0;
            if (lsu_valid) begin
                m_sv = 1; m_sr = lsu_rd; m_sd = lsu_wdata;
            end else if (!flush && mq.size() > 0) begin
                m_sv = 1; {m_sr, m_sd} = mq.pop_front();
            end
            if (flush) begin
                mq.delete();
                mp = '0;
            end else begin
                if (fpu_valid && m_fr) mq.push_back({fpu_rd, fpu_wdata});
                if (m_sv) mp[m_sr] = 1'b0;
                if (issue_valid && m_ir) mp[issue_rd] = 1'b1;
            end
            ew = m_sv;
            if (m_sv) begin ea = m_sr; ed = m_sd; end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("we", we, ew);
            chk("waddr", waddr, ea);
            chk("wdata", wdata, ed);
            chk("fpu_ready", fpu_ready, mq.size() < DEPTH);
            chk("issue_ready", issue_ready, !mp[issue_rd]);
            chk("raw_stall", raw_stall,
                (rs_use[0] & mp[rs_a]) | (rs_use[1] & mp[rs_b]) | (rs_use[2] & mp[rs_c]));
            if (we === 1'b1) wlog.push_back(waddr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp3[7];
        bit acc;
        exp3 = '{5, 5, 5, 5, 1, 2, 7};
        flush = 0; issue_valid = 1; issue_rd = 5'd2;
        rs_a = 0; rs_b = 0; rs_c = 0; rs_use = 3'b000;
        fpu_valid = 1; fpu_rd = 5'd1; fpu_wdata = 32'h1;
        lsu_valid = 0; lsu_rd = 0; lsu_wdata = 0;
        rst_n = 0;

        // Reset with traffic asserted
        repeat (2) step();
        rst_n = 1; fpu_valid = 0; issue_valid = 0;
        #1;
        chk("rst_we", we, 0);
        chk("rst_fpu_ready", fpu_ready, 1);
        for (int i = 0; i < 32; i++) begin
            issue_rd = 5'(i);
            #1;
            chk("rst_pending_clear", issue_ready, 1);
        end
        issue_rd = 0;
        step();

        // FPU latency: accepted in cycle 0, write visible in cycle 2 only
        fpu_valid = 1; fpu_rd = 5'd3; fpu_wdata = 32'h3F80_0000;
        step();
        fpu_valid = 0;
        chk("lat_c1_we", we, 0);
        step();
        chk("lat_c2_we", we, 1);
        chk("lat_c2_waddr", waddr, 3);
        chk("lat_c2_wdata", wdata, 32'h3F80_0000);
        step();
        chk("lat_c3_we", we, 0);
        step();

        // LSU priority and FIFO backpressure
        wlog.delete();
        lsu_valid = 1; lsu_rd = 5'd5; lsu_wdata = 32'h5555;
        fpu_valid = 1; fpu_rd = 5'd1; fpu_wdata = 32'h1111;
        step();
        fpu_rd = 5'd2; fpu_wdata = 32'h2222;
        step();
        fpu_rd = 5'd7; fpu_wdata = 32'h7777;
        #1;
        chk("full_ready", fpu_ready, 0);
        step();
        step();
        lsu_valid = 0;
        acc = 0;
        for (int n = 0; n < 10 && !acc; n++) begin
            acc = fpu_ready;
            step();
        end
        chk("ready_wait", acc, 1);
        fpu_valid = 0;
        repeat (4) step();
        chk("order_len", wlog.size(), 7);
        for (int i = 0; i < 7 && i < wlog.size(); i++) chk("order_rd", wlog[i], exp3[i]);

        // Scoreboard RAW/WAW
        issue_valid = 1; issue_rd = 5'd9;
        step();
        rs_a = 5'd9; rs_use = 3'b001;
        fpu_valid = 1; fpu_rd = 5'd9; fpu_wdata = 32'h9999;
        #1;
        chk("raw_set", raw_stall, 1);
        chk("waw_stall", issue_ready, 0);
        step();
        issue_valid = 0; fpu_valid = 0;
        step();
        chk("sb_we", we, 1);
        chk("sb_waddr", waddr, 9);
        step();
        chk("raw_clear", raw_stall, 0);
        chk("waw_clear", issue_ready, 1);
        rs_use = 3'b000;

        // Same-edge set and clear of rd=4
        lsu_valid = 1; lsu_rd = 5'd4; lsu_wdata = 32'h4444;
        issue_valid = 1; issue_rd = 5'd4;
        step();
        lsu_valid = 0; issue_valid = 0;
        #1;
        chk("collide_pending", issue_ready, 0);
        lsu_valid = 1;
        step();
        lsu_valid = 0;
        step();
        chk("collide_cleared", issue_ready, 1);

        // Flush with buffered FPU results and a concurrent LSU write
        wlog.delete();
        lsu_valid = 1; lsu_rd = 5'd8; lsu_wdata = 32'h8888;
        fpu_valid = 1; fpu_rd = 5'd10; fpu_wdata = 32'hAAAA;
        issue_valid = 1; issue_rd = 5'd12;
        step();
        fpu_rd = 5'd11; fpu_wdata = 32'hBBBB; issue_valid = 0;
        step();
        flush = 1; lsu_rd = 5'd6; lsu_wdata = 32'h6666;
        fpu_rd = 5'd14; issue_valid = 1; issue_rd = 5'd13;
        #1;
        chk("pre_flush_full", fpu_ready, 0);
        step();
        flush = 0; lsu_valid = 0; fpu_valid = 0; issue_valid = 0;
        #1;
        chk("flush_ready", fpu_ready, 1);
        chk("flush_pend13", issue_ready, 1);
        issue_rd = 5'd12;
        #1;
        chk("flush_pend12", issue_ready, 1);
        repeat (4) step();
        chk("flush_len", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("flush_w0", wlog[0], 8);
            chk("flush_w1", wlog[1], 8);
            chk("flush_w2", wlog[2], 6);
        end

        // Reset mid-flight drops the buffered FPU result
        fpu_valid = 1; fpu_rd = 5'd20; fpu_wdata = 32'h2020;
        step();
        fpu_valid = 0; rst_n = 0;
        step();
        rst_n = 1;
        chk("midrst_we0", we, 0);
        step();
        chk("midrst_we1", we, 0);
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
